// File: rtl/apb_arbiter.sv
// Two-master APB arbiter: registers the winner's setup phase, runs one shared-bus transfer and
// returns a one-cycle response. Define APB_ARB_RR_EN for round-robin ties; default is m0-first priority.
module apb_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rts,
  input  logic [ADDR_WIDTH-1:0] m0_paddr,
  input  logic [DATA_WIDTH-1:0] m0_pdata,
  input  logic                  m0_psel,
  input  logic                  m0_penable,
  input  logic                  m0_pwrite,
  input  logic [3:0]            m0_pstb,
  output logic [DATA_WIDTH-1:0] m0_prdata,
  output logic                  m0_pready,
  output logic                  m0_perr,
  input  logic [ADDR_WIDTH-1:0] m1_paddr,
  input  logic [DATA_WIDTH-1:0] m1_pdata,
  input  logic                  m1_psel,
  input  logic                  m1_penable,
  input  logic                  m1_pwrite,
  input  logic [3:0]            m1_pstb,
  output logic [DATA_WIDTH-1:0] m1_prdata,
  output logic                  m1_pready,
  output logic                  m1_perr,
  output logic [ADDR_WIDTH-1:0] s_paddr,
  output logic [DATA_WIDTH-1:0] s_pdata,
  output logic                  s_psel,
  output logic                  s_penable,
  output logic                  s_pwrite,
  output logic [3:0]            s_pstb,
  input  logic [DATA_WIDTH-1:0] s_prdata,
  input  logic                  s_pready,
  input  logic                  s_perr,
  output logic                  grant
);

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t                r_state;
  logic [WD_W-1:0]       r_wd;
  logic [ADDR_WIDTH-1:0] r_s_paddr;
  logic [DATA_WIDTH-1:0] r_s_pdata;
  logic                  r_s_psel;
  logic                  r_s_penable;
  logic                  r_s_pwrite;
  logic [3:0]            r_s_pstb;
  logic                  r_grant;
  logic [DATA_WIDTH-1:0] r_m0_prdata;
  logic                  r_m0_pready;
  logic                  r_m0_perr;
  logic [DATA_WIDTH-1:0] r_m1_prdata;
  logic                  r_m1_pready;
  logic                  r_m1_perr;

  logic                  w_req;
  logic                  w_win;
  logic                  w_timeout;
  logic                  w_finish;
  logic                  w_err;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused;

  // Master enables are accepted on the port but sequencing comes from psel alone.
  assign w_unused = m0_penable ^ m1_penable;
  assign w_req    = m0_psel | m1_psel;

`ifdef APB_ARB_RR_EN
  logic r_prio;  // master favoured on a tie: the one not granted last
  assign w_win = (m0_psel && m1_psel) ? r_prio : m1_psel;
`else
  assign w_win = ~m0_psel;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    w_timeout = 1'b0;
    if (TIMEOUT != 0) w_timeout = (r_wd == WD_LAST);
    w_finish = s_pready | w_timeout;
    w_rdata  = s_pready ? s_prdata : '0;
    w_err    = s_pready ? s_perr : 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rts) begin
    if (rts) begin
      r_state     <= IDLE;
      r_wd        <= '0;
      r_s_paddr   <= '0;
      r_s_pdata   <= '0;
      r_s_psel    <= 1'b0;
      r_s_penable <= 1'b0;
      r_s_pwrite  <= 1'b0;
      r_s_pstb    <= '0;
      r_grant     <= 1'b0;
      r_m0_prdata <= '0;
      r_m0_pready <= 1'b0;
      r_m0_perr   <= 1'b0;
      r_m1_prdata <= '0;
      r_m1_pready <= 1'b0;
      r_m1_perr   <= 1'b0;
`ifdef APB_ARB_RR_EN
      r_prio      <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_grant    <= w_win;
            r_s_paddr  <= w_win ? m1_paddr  : m0_paddr;
            r_s_pdata  <= w_win ? m1_pdata  : m0_pdata;
            r_s_pwrite <= w_win ? m1_pwrite : m0_pwrite;
            r_s_pstb   <= w_win ? m1_pstb   : m0_pstb;
            r_s_psel   <= 1'b1;
            r_wd       <= '0;
`ifdef APB_ARB_RR_EN
            r_prio     <= ~w_win;
`endif
            r_state    <= SETUP;
          end
        end
        SETUP: begin
          r_s_penable <= 1'b1;
          r_state     <= ACCESS;
        end
        ACCESS: begin
          if (w_finish) begin
            r_s_psel    <= 1'b0;
            r_s_penable <= 1'b0;
            if (r_grant) begin
              r_m1_pready <= 1'b1;
              r_m1_perr   <= w_err;
              r_m1_prdata <= w_rdata;
            end else begin
              r_m0_pready <= 1'b1;
              r_m0_perr   <= w_err;
              r_m0_prdata <= w_rdata;
            end
            r_state <= DONE;
          end else if (r_wd != WD_MAX) begin
            r_wd <= r_wd + 1'b1;
          end
        end
        DONE: begin
          r_m0_pready <= 1'b0;
          r_m0_perr   <= 1'b0;
          r_m1_pready <= 1'b0;
          r_m1_perr   <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_paddr   = r_s_paddr;
  assign s_pdata   = r_s_pdata;
  assign s_psel    = r_s_psel;
  assign s_penable = r_s_penable;
  assign s_pwrite  = r_s_pwrite;
  assign s_pstb    = r_s_pstb;
  assign grant     = r_grant;
  assign m0_prdata = r_m0_prdata;
  assign m0_pready = r_m0_pready;
  assign m0_perr   = r_m0_perr;
  assign m1_prdata = r_m1_prdata;
  assign m1_pready = r_m1_pready;
  assign m1_perr   = r_m1_perr;

endmodule
